// File: rtl/program_memory_loader.sv
// Boot-time program memory loader.
// Receives a byte stream (16-bit word count, little-endian data words,
// XOR checksum) over valid/ready, writes each assembled word into the
// text segment and holds the core in reset until the image is verified.
module program_memory_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  write_enable_o,
    output logic [DATA_WIDTH-1:0] write_address_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  core_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int          IDX_W   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [15:0] LEN_MAX = 16'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              byte_cnt_r;
    logic [7:0]              len_lo_r;
    logic [15:0]             len_r;
    logic [IDX_W-1:0]        word_index_r;
    logic [DATA_WIDTH-1:0]   word_r;
    logic [DATA_WIDTH-1:0]   addr_r;
    logic [7:0]              csum_r;

    logic                    ready_r;
    logic                    we_r;
    logic                    hold_r;
    logic                    done_r;
    logic                    error_r;

    logic                    xfer_s;
    logic [15:0]             len_in_s;
    logic                    len_bad_s;
    logic                    last_word_s;

    // A byte moves only when the registered ready and the source's valid coincide.
    assign xfer_s      = byte_valid_i && ready_r;
    assign len_in_s    = {byte_i, len_lo_r};
    assign len_bad_s   = (len_in_s == 16'd0) || (len_in_s > LEN_MAX);
    // Index stops at N-1 so it never runs past the last legal word.
    assign last_word_s = (16'(word_index_r) == (len_r - 16'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_s = ST_LEN_LO;
                else         state_s = ST_IDLE;
            end
            ST_LEN_LO: begin
                if (xfer_s) state_s = ST_LEN_HI;
                else        state_s = ST_LEN_LO;
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    if (len_bad_s) state_s = ST_ERROR;
                    else           state_s = ST_DATA;
                end else begin
                    state_s = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                if (xfer_s && (byte_cnt_r == 2'd3)) state_s = ST_WRITE;
                else                                state_s = ST_DATA;
            end
            ST_WRITE: begin
                if (last_word_s) state_s = ST_CHECK;
                else             state_s = ST_DATA;
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    if (byte_i == csum_r) state_s = ST_DONE;
                    else                  state_s = ST_ERROR;
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_DONE: begin
                if (start_i) state_s = ST_LEN_LO;
                else         state_s = ST_DONE;
            end
            ST_ERROR: begin
                if (start_i) state_s = ST_LEN_LO;
                else         state_s = ST_ERROR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            we_r    <= 1'b0;
            hold_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_LEN_LO) || (state_s == ST_LEN_HI) ||
                       (state_s == ST_DATA)   || (state_s == ST_CHECK);
            we_r    <= (state_s == ST_WRITE);
            hold_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r  <= (state_s == ST_DONE);
            error_r <= (state_s == ST_ERROR);
        end
    end

    // Datapath: length capture, word assembly, checksum and write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r   <= 2'd0;
            len_lo_r     <= 8'd0;
            len_r        <= 16'd0;
            word_index_r <= '0;
            word_r       <= '0;
            addr_r       <= '0;
            csum_r       <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        byte_cnt_r   <= 2'd0;
                        len_lo_r     <= 8'd0;
                        len_r        <= 16'd0;
                        word_index_r <= '0;
                        csum_r       <= 8'd0;
                    end else begin
                        byte_cnt_r   <= byte_cnt_r;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) len_lo_r <= byte_i;
                    else        len_lo_r <= len_lo_r;
                end
                ST_LEN_HI: begin
                    if (xfer_s) len_r <= len_in_s;
                    else        len_r <= len_r;
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        // First byte of a word ends up in bits [7:0] after four shifts.
                        word_r     <= {byte_i, word_r[DATA_WIDTH-1:8]};
                        csum_r     <= csum_r ^ byte_i;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            addr_r <= TEXT_BASE + (DATA_WIDTH'(word_index_r) << 2);
                        end else begin
                            addr_r <= addr_r;
                        end
                    end else begin
                        word_r <= word_r;
                    end
                end
                ST_WRITE: begin
                    if (!last_word_s) word_index_r <= word_index_r + IDX_W'(1);
                    else              word_index_r <= word_index_r;
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    assign byte_ready_o    = ready_r;
    assign write_enable_o  = we_r;
    assign write_address_o = addr_r;
    assign write_data_o    = word_r;
    assign core_hold_o     = hold_r;
    assign done_o          = done_r;
    assign error_o         = error_r;

endmodule
